// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter for a single memory port.
// One transaction in flight; round-robin on ties, fetch flush, and a response timeout.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                if_req_valid_i,
    output logic                if_req_ready_o,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_rsp_valid_o,
    input  logic                if_rsp_ready_i,
    output logic [DATA_W-1:0]   if_rsp_data_o,
    output logic                if_rsp_err_o,
    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic                lsu_we_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    output logic                lsu_rsp_valid_o,
    input  logic                lsu_rsp_ready_i,
    output logic [DATA_W-1:0]   lsu_rsp_data_o,
    output logic                lsu_rsp_err_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_rsp_valid_i,
    output logic                mem_rsp_ready_o,
    input  logic [DATA_W-1:0]   mem_rsp_data_i,
    input  logic                mem_rsp_err_i,
    output logic                busy_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_t;

    state_t              state_reg, state_next;
    logic                owner_lsu_reg, owner_lsu_next;
    logic                last_lsu_reg, last_lsu_next;
    logic                discard_reg, discard_next;
    logic                timed_out_reg, timed_out_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                we_reg, we_next;
    logic [BE_W-1:0]     be_reg, be_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                err_reg, err_next;

    logic if_req_eff;
    logic grant_lsu;
    logic grant_if;
    logic flush_if;
    logic discard_eff;
    logic timeout_hit;
    logic resp_done;

    // A flushed fetch must not be granted, so flush masks the IF request before arbitration.
    assign if_req_eff  = if_req_valid_i & ~flush_i;
    assign grant_lsu   = lsu_req_valid_i & (~if_req_eff | ~last_lsu_reg);
    assign grant_if    = if_req_eff & ~grant_lsu;
    assign flush_if    = flush_i & ~owner_lsu_reg;
    assign discard_eff = discard_reg | flush_if;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST);

    assign mem_addr_o  = addr_reg;
    assign mem_we_o    = we_reg;
    assign mem_be_o    = be_reg;
    assign mem_wdata_o = wdata_reg;
    assign busy_o      = (state_reg != ST_IDLE);

    always_comb begin
        state_next      = state_reg;
        owner_lsu_next  = owner_lsu_reg;
        last_lsu_next   = last_lsu_reg;
        discard_next    = discard_reg;
        timed_out_next  = timed_out_reg;
        cnt_next        = cnt_reg;
        addr_next       = addr_reg;
        we_next         = we_reg;
        be_next         = be_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;
        resp_done       = 1'b0;
        if_req_ready_o  = 1'b0;
        lsu_req_ready_o = 1'b0;
        if_rsp_valid_o  = 1'b0;
        if_rsp_data_o   = '0;
        if_rsp_err_o    = 1'b0;
        lsu_rsp_valid_o = 1'b0;
        lsu_rsp_data_o  = '0;
        lsu_rsp_err_o   = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_rsp_ready_o = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if_req_ready_o  = grant_if;
                lsu_req_ready_o = grant_lsu;
                discard_next    = 1'b0;
                if (grant_lsu) begin
                    addr_next      = lsu_addr_i;
                    we_next        = lsu_we_i;
                    be_next        = lsu_be_i;
                    wdata_next     = lsu_wdata_i;
                    owner_lsu_next = 1'b1;
                    last_lsu_next  = 1'b1;
                    state_next     = ST_ISSUE;
                end else if (grant_if) begin
                    addr_next      = if_addr_i;
                    we_next        = 1'b0;
                    be_next        = '1;
                    wdata_next     = '0;
                    owner_lsu_next = 1'b0;
                    last_lsu_next  = 1'b0;
                    state_next     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // The request stays up even when flushed; the response is dropped later.
                mem_req_valid_o = 1'b1;
                if (flush_if) begin
                    discard_next = 1'b1;
                end
                if (mem_req_ready_i) begin
                    cnt_next   = '0;
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                mem_rsp_ready_o = 1'b1;
                if (flush_if) begin
                    discard_next = 1'b1;
                end
                if (mem_rsp_valid_i) begin
                    rdata_next = we_reg ? '0 : mem_rsp_data_i;
                    err_next   = mem_rsp_err_i;
                    if (discard_eff) begin
                        discard_next = 1'b0;
                        state_next   = ST_IDLE;
                    end else begin
                        state_next = ST_RESP;
                    end
                end else if (timeout_hit) begin
                    rdata_next     = '0;
                    err_next       = 1'b1;
                    timed_out_next = 1'b1;
                    state_next     = discard_eff ? ST_DRAIN : ST_RESP;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_RESP: begin
                if (owner_lsu_reg) begin
                    lsu_rsp_valid_o = 1'b1;
                    lsu_rsp_data_o  = rdata_reg;
                    lsu_rsp_err_o   = err_reg;
                    resp_done       = lsu_rsp_ready_i;
                end else if (flush_i) begin
                    resp_done = 1'b1;
                end else begin
                    if_rsp_valid_o = 1'b1;
                    if_rsp_data_o  = rdata_reg;
                    if_rsp_err_o   = err_reg;
                    resp_done      = if_rsp_ready_i;
                end
                if (resp_done) begin
                    state_next = timed_out_reg ? ST_DRAIN : ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // Absorb the late response belonging to the timed-out transaction.
                mem_rsp_ready_o = 1'b1;
                if (mem_rsp_valid_i) begin
                    timed_out_next = 1'b0;
                    discard_next   = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            owner_lsu_reg <= 1'b0;
            last_lsu_reg  <= 1'b0;
            discard_reg   <= 1'b0;
            timed_out_reg <= 1'b0;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            be_reg        <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_lsu_reg <= owner_lsu_next;
            last_lsu_reg  <= last_lsu_next;
            discard_reg   <= discard_next;
            timed_out_reg <= timed_out_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            we_reg        <= we_next;
            be_reg        <= be_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares on every response handshake.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int TO     = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              if_req_valid_i;
    logic              if_req_ready_o;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_rsp_valid_o;
    logic              if_rsp_ready_i;
    logic [DATA_W-1:0] if_rsp_data_o;
    logic              if_rsp_err_o;
    logic              lsu_req_valid_i;
    logic              lsu_req_ready_o;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic              lsu_we_i;
    logic [BE_W-1:0]   lsu_be_i;
    logic [DATA_W-1:0] lsu_wdata_i;
    logic              lsu_rsp_valid_o;
    logic              lsu_rsp_ready_i;
    logic [DATA_W-1:0] lsu_rsp_data_o;
    logic              lsu_rsp_err_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_rsp_valid_i;
    logic              mem_rsp_ready_o;
    logic [DATA_W-1:0] mem_rsp_data_i;
    logic              mem_rsp_err_i;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .if_req_valid_i(if_req_valid_i),
        .if_req_ready_o(if_req_ready_o),
        .if_addr_i(if_addr_i),
        .if_rsp_valid_o(if_rsp_valid_o),
        .if_rsp_ready_i(if_rsp_ready_i),
        .if_rsp_data_o(if_rsp_data_o),
        .if_rsp_err_o(if_rsp_err_o),
        .lsu_req_valid_i(lsu_req_valid_i),
        .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_addr_i(lsu_addr_i),
        .lsu_we_i(lsu_we_i),
        .lsu_be_i(lsu_be_i),
        .lsu_wdata_i(lsu_wdata_i),
        .lsu_rsp_valid_o(lsu_rsp_valid_o),
        .lsu_rsp_ready_i(lsu_rsp_ready_i),
        .lsu_rsp_data_o(lsu_rsp_data_o),
        .lsu_rsp_err_o(lsu_rsp_err_o),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_ready_o(mem_rsp_ready_o),
        .mem_rsp_data_i(mem_rsp_data_i),
        .mem_rsp_err_i(mem_rsp_err_i),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic        is_lsu;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   mem_delay  = 0;
    bit   mem_silent = 1'b0;
    int   stale_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       busy_o, 0);
        check({tag, "_if_rdy"},     if_req_ready_o, 0);
        check({tag, "_lsu_rdy"},    lsu_req_ready_o, 0);
        check({tag, "_if_rspv"},    if_rsp_valid_o, 0);
        check({tag, "_lsu_rspv"},   lsu_rsp_valid_o, 0);
        check({tag, "_if_data"},    if_rsp_data_o, 0);
        check({tag, "_lsu_data"},   lsu_rsp_data_o, 0);
        check({tag, "_errs"},       {if_rsp_err_o, lsu_rsp_err_o}, 0);
        check({tag, "_mem_reqv"},   mem_req_valid_o, 0);
        check({tag, "_mem_rsprdy"}, mem_rsp_ready_o, 0);
        check({tag, "_mem_addr"},   mem_addr_o, 0);
        check({tag, "_mem_we_be"},  {mem_we_o, mem_be_o}, 0);
        check({tag, "_mem_wdata"},  mem_wdata_o, 0);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy_o && k < 50) begin
            tick();
            #2;
            k++;
        end
        check(name, busy_o, 0);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_0104: return 32'hDEAD_BEEF;
            32'h0000_0200: return 32'h0011_2233;
            32'h0000_0300: return 32'hCAFE_F00D;
            default:       return 32'h0BAD_F00D;
        endcase
    endfunction

    // Memory model: responds mem_delay cycles after the WAIT cycle following acceptance.
    initial begin : mem_model
        logic        pend;
        int          cnt;
        int          stale_done;
        logic [31:0] la;
        pend = 1'b0;
        cnt = 0;
        stale_done = 0;
        la = '0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        mem_rsp_err_i   = 1'b0;
        forever begin
            @(negedge clk_i);
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = '0;
            if (rst_i) pend = 1'b0;
            if (stale_cnt != stale_done) begin
                stale_done++;
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = 32'h5757_5757;
            end else if (pend) begin
                if (cnt == 0) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_data_i  = mem_data(la);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (mem_req_valid_o && mem_req_ready_i && !rst_i && !mem_silent) begin
                pend = 1'b1;
                cnt  = mem_delay;
                la   = mem_addr_o;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (if_rsp_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("if_rsp_unexpected", exp_q.size(), 1);
                    end else begin
                        check("if_rsp_owner", exp_q[0].is_lsu, 0);
                        if (if_rsp_ready_i && !exp_q[0].is_lsu) begin
                            e = exp_q.pop_front();
                            check("if_rsp_data", if_rsp_data_o, e.data);
                            check("if_rsp_err", if_rsp_err_o, e.err);
                            $display("[%0t] IF  rsp data=0x%08h err=%0b", $time, if_rsp_data_o, if_rsp_err_o);
                        end
                    end
                end
                if (lsu_rsp_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("lsu_rsp_unexpected", exp_q.size(), 1);
                    end else begin
                        check("lsu_rsp_owner", exp_q[0].is_lsu, 1);
                        if (lsu_rsp_ready_i && exp_q[0].is_lsu) begin
                            e = exp_q.pop_front();
                            check("lsu_rsp_data", lsu_rsp_data_o, e.data);
                            check("lsu_rsp_err", lsu_rsp_err_o, e.err);
                            $display("[%0t] LSU rsp data=0x%08h err=%0b", $time, lsu_rsp_data_o, lsu_rsp_err_o);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit lsu_turn;
        rst_i = 1'b1;
        flush_i = 1'b0;
        if_req_valid_i = 1'b0;
        if_addr_i = '0;
        if_rsp_ready_i = 1'b1;
        lsu_req_valid_i = 1'b0;
        lsu_addr_i = '0;
        lsu_we_i = 1'b0;
        lsu_be_i = '0;
        lsu_wdata_i = '0;
        lsu_rsp_ready_i = 1'b1;
        mem_req_ready_i = 1'b1;

        tick();
        tick();
        #2;
        check_all_zero("reset");
        tick();
        rst_i = 1'b0;

        // Single IF fetch with zero-wait memory
        tick();
        if_req_valid_i = 1'b1;
        if_addr_i = 32'h100;
        #2;
        check("t1_if_ready", if_req_ready_o, 1);
        check("t1_lsu_ready", lsu_req_ready_o, 0);
        exp_q.push_back(exp_t'{1'b0, 32'h0000_0013, 1'b0});
        tick();
        if_req_valid_i = 1'b0;
        #2;
        check("t1_mem_valid", mem_req_valid_o, 1);
        check("t1_mem_addr", mem_addr_o, 32'h100);
        check("t1_mem_we_be", {mem_we_o, mem_be_o}, 5'b0_1111);
        check("t1_mem_wdata", mem_wdata_o, 0);
        tick();
        #2;
        check("t1_wait_rsprdy", mem_rsp_ready_o, 1);
        check("t1_wait_rspv", if_rsp_valid_o, 0);
        tick();
        #2;
        check("t1_rsp_valid", if_rsp_valid_o, 1);
        check("t1_rsp_data", if_rsp_data_o, 32'h13);
        check("t1_lsu_quiet", lsu_rsp_valid_o, 0);
        tick();
        #2;
        check("t1_busy_low", busy_o, 0);

        // Continuous tie from reset: LSU, IF, LSU, IF
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        if_req_valid_i = 1'b1;
        if_addr_i = 32'h200;
        lsu_req_valid_i = 1'b1;
        lsu_addr_i = 32'h2000;
        lsu_we_i = 1'b1;
        lsu_be_i = 4'b0011;
        lsu_wdata_i = 32'hAABB_CCDD;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            #2;
            lsu_turn = (k % 2 == 0);
            check("t2_lsu_grant", lsu_req_ready_o, lsu_turn);
            check("t2_if_grant", if_req_ready_o, !lsu_turn);
            if (lsu_turn) exp_q.push_back(exp_t'{1'b1, 32'h0, 1'b0});
            else          exp_q.push_back(exp_t'{1'b0, 32'h0011_2233, 1'b0});
            tick();
            #2;
            check("t2_mem_valid", mem_req_valid_o, 1);
            if (lsu_turn) begin
                check("t2_mem_addr", mem_addr_o, 32'h2000);
                check("t2_mem_we_be", {mem_we_o, mem_be_o}, 5'b1_0011);
                check("t2_mem_wdata", mem_wdata_o, 32'hAABB_CCDD);
            end else begin
                check("t2_mem_addr", mem_addr_o, 32'h200);
                check("t2_mem_we_be", {mem_we_o, mem_be_o}, 5'b0_1111);
                check("t2_mem_wdata", mem_wdata_o, 0);
            end
            tick();
            tick();
            #2;
            check("t2_rsp_owner", {lsu_rsp_valid_o, if_rsp_valid_o}, lsu_turn ? 2'b10 : 2'b01);
        end
        tick();
        if_req_valid_i = 1'b0;
        lsu_req_valid_i = 1'b0;
        lsu_we_i = 1'b0;
        lsu_be_i = 4'hF;
        lsu_wdata_i = '0;
        #2;
        check("t2_idle", busy_o, 0);

        // Back-pressure on the request and on the LSU response
        tick();
        lsu_req_valid_i = 1'b1;
        lsu_addr_i = 32'h300;
        if_req_valid_i = 1'b1;
        if_addr_i = 32'h100;
        mem_req_ready_i = 1'b0;
        #2;
        check("t3_lsu_grant", lsu_req_ready_o, 1);
        check("t3_if_nogrant", if_req_ready_o, 0);
        exp_q.push_back(exp_t'{1'b1, 32'hCAFE_F00D, 1'b0});
        for (int k = 0; k < 3; k++) begin
            tick();
            lsu_req_valid_i = 1'b0;
            #2;
            check("t3_hold_valid", mem_req_valid_o, 1);
            check("t3_hold_addr", mem_addr_o, 32'h300);
            check("t3_hold_we_be", {mem_we_o, mem_be_o}, 5'b0_1111);
            check("t3_no_grant", if_req_ready_o, 0);
        end
        tick();
        mem_req_ready_i = 1'b1;
        #2;
        check("t3_accept_addr", mem_addr_o, 32'h300);
        tick();
        #2;
        check("t3_wait", mem_rsp_ready_o, 1);
        tick();
        lsu_rsp_ready_i = 1'b0;
        #2;
        check("t3_rsp_hold0", lsu_rsp_valid_o, 1);
        check("t3_rsp_data0", lsu_rsp_data_o, 32'hCAFE_F00D);
        tick();
        #2;
        check("t3_rsp_hold1", lsu_rsp_valid_o, 1);
        check("t3_rsp_data1", lsu_rsp_data_o, 32'hCAFE_F00D);
        check("t3_rsp_nogrant", if_req_ready_o, 0);
        tick();
        lsu_rsp_ready_i = 1'b1;
        #2;
        check("t3_rsp_hs", lsu_rsp_valid_o, 1);
        tick();
        #2;
        check("t3_if_grant", if_req_ready_o, 1);
        exp_q.push_back(exp_t'{1'b0, 32'h0000_0013, 1'b0});
        tick();
        if_req_valid_i = 1'b0;
        wait_idle("t3_idle");

        // Fetch flushed while waiting for memory
        mem_delay = 2;
        tick();
        if_req_valid_i = 1'b1;
        if_addr_i = 32'h104;
        #2;
        check("t4_if_grant", if_req_ready_o, 1);
        tick();
        if_req_valid_i = 1'b0;
        lsu_req_valid_i = 1'b1;
        lsu_addr_i = 32'h300;
        #2;
        check("t4_issue", mem_req_valid_o, 1);
        check("t4_lsu_blocked", lsu_req_ready_o, 0);
        tick();
        flush_i = 1'b1;
        #2;
        check("t4_wait", mem_rsp_ready_o, 1);
        check("t4_if_rspv_a", if_rsp_valid_o, 0);
        tick();
        flush_i = 1'b0;
        #2;
        check("t4_if_rspv_b", if_rsp_valid_o, 0);
        check("t4_lsu_blocked2", lsu_req_ready_o, 0);
        tick();
        #2;
        check("t4_busy_rsp", busy_o, 1);
        check("t4_if_rspv_c", if_rsp_valid_o, 0);
        tick();
        #2;
        check("t4_idle", busy_o, 0);
        check("t4_if_rspv_d", if_rsp_valid_o, 0);
        check("t4_lsu_grant", lsu_req_ready_o, 1);
        exp_q.push_back(exp_t'{1'b1, 32'hCAFE_F00D, 1'b0});
        tick();
        lsu_req_valid_i = 1'b0;
        mem_delay = 0;
        wait_idle("t4_done");

        // Timeout with a silent memory, then drain of the stale response
        mem_silent = 1'b1;
        tick();
        lsu_req_valid_i = 1'b1;
        lsu_addr_i = 32'h300;
        #2;
        check("t5_lsu_grant", lsu_req_ready_o, 1);
        exp_q.push_back(exp_t'{1'b1, 32'h0, 1'b1});
        tick();
        lsu_req_valid_i = 1'b0;
        if_req_valid_i = 1'b1;
        if_addr_i = 32'h100;
        #2;
        check("t5_issue", mem_req_valid_o, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            #2;
            check("t5_wait_rdy", mem_rsp_ready_o, 1);
            check("t5_wait_rspv", lsu_rsp_valid_o, 0);
            check("t5_wait_nogrant", if_req_ready_o, 0);
        end
        tick();
        #2;
        check("t5_to_valid", lsu_rsp_valid_o, 1);
        check("t5_to_err", lsu_rsp_err_o, 1);
        check("t5_to_data", lsu_rsp_data_o, 0);
        tick();
        #2;
        check("t5_drain_busy", busy_o, 1);
        check("t5_drain_rdy", mem_rsp_ready_o, 1);
        check("t5_drain_nogrant", if_req_ready_o, 0);
        check("t5_drain_rspv", lsu_rsp_valid_o, 0);
        tick();
        stale_cnt++;
        mem_silent = 1'b0;
        #2;
        check("t5_drain_nogrant2", if_req_ready_o, 0);
        tick();
        #2;
        check("t5_after_drain", if_req_ready_o, 1);
        exp_q.push_back(exp_t'{1'b0, 32'h0000_0013, 1'b0});
        tick();
        if_req_valid_i = 1'b0;
        wait_idle("t5_done");

        // Reset in the middle of WAIT
        mem_silent = 1'b1;
        tick();
        lsu_req_valid_i = 1'b1;
        lsu_addr_i = 32'h300;
        #2;
        check("t6_lsu_grant", lsu_req_ready_o, 1);
        tick();
        lsu_req_valid_i = 1'b0;
        #2;
        check("t6_issue", mem_req_valid_o, 1);
        tick();
        #2;
        check("t6_wait", mem_rsp_ready_o, 1);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #2;
        check_all_zero("t6_post_reset");
        tick();
        mem_silent = 1'b0;
        lsu_req_valid_i = 1'b1;
        if_req_valid_i = 1'b1;
        #2;
        check("t6_tie_lsu", lsu_req_ready_o, 1);
        check("t6_tie_if", if_req_ready_o, 0);
        exp_q.push_back(exp_t'{1'b1, 32'hCAFE_F00D, 1'b0});
        tick();
        lsu_req_valid_i = 1'b0;
        if_req_valid_i = 1'b0;
        wait_idle("t6_done");

        tick();
        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
